// File: rtl/an_sec_pkg.sv
// Shared constants, types and modular helper for the AN(13837) SEC decoder.
package an_sec_pkg;

    localparam int CW_W    = 38;
    localparam int R_W     = 14;
    localparam int A_CONST = 13837;
    localparam int NLOC    = 38;

    localparam logic [R_W-1:0] A_R = R_W'(A_CONST);

    typedef enum logic [2:0] {
        IDLE,
        SYND,
        CHK,
        SEARCH,
        CORR,
        DONE
    } state_t;

    typedef struct packed {
        logic no_err;
        logic corr;
        logic uncorr;
    } status_t;

    // x < A and b <= 1 keep 2x+b below 2A, so one subtract suffices.
    function automatic logic [R_W-1:0] mod_dbl(
        input logic [R_W-1:0] x,
        input logic           b
    );
        logic [R_W:0] t;
        t = {x, b};
        if (t >= (R_W+1)'(A_CONST))
            t = t - (R_W+1)'(A_CONST);
        return t[R_W-1:0];
    endfunction

endpackage

// File: rtl/an_sec_decode_ctrl_if.sv
// Codeword-in / result-out handshake bundle of the AN SEC decoder.
interface an_sec_decode_ctrl_if;
    import an_sec_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [CW_W-1:0] in_cw;
    logic            out_valid;
    logic            out_ready;
    logic [CW_W-1:0] out_cw;
    logic [R_W-1:0]  out_syn;
    logic [6:0]      out_loc;
    logic            out_no_err;
    logic            out_corr;
    logic            out_uncorr;

    modport master (
        output in_valid, in_cw, out_ready,
        input  in_ready, out_valid, out_cw, out_syn,
        input  out_loc, out_no_err, out_corr, out_uncorr
    );

    modport slave (
        input  in_valid, in_cw, out_ready,
        output in_ready, out_valid, out_cw, out_syn,
        output out_loc, out_no_err, out_corr, out_uncorr
    );

endinterface

// File: rtl/an_mod_serial.sv
// Bit-serial MSB-first residue accumulator: s <= (2s + din) mod A.
module an_mod_serial
    import an_sec_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           step,
    input  logic           din,
    output logic [R_W-1:0] s
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s <= '0;
        else if (clr)
            s <= '0;
        else if (step)
            s <= mod_dbl(s, din);
    end

endmodule

// File: rtl/an_sec_decode_ctrl.sv
// Sequential single-error-correcting AN code decoder: syndrome, search, fix.
module an_sec_decode_ctrl
    import an_sec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    an_sec_decode_ctrl_if.slave  bus,
    output logic                 busy
);

    state_t          state;
    logic [CW_W-1:0] word;
    logic [5:0]      idx;
    logic [5:0]      k;
    logic [R_W-1:0]  p;
    logic            neg;
    status_t         flags;
    logic            in_ready;
    logic            out_valid;
    logic [CW_W-1:0] out_cw;
    logic [R_W-1:0]  out_syn;
    logic [6:0]      out_loc;
    logic [R_W-1:0]  s;
    logic            accept;
    logic [CW_W:0]   delta;
    logic [CW_W:0]   sum;
    logic [6:0]      mag;

    assign accept = (state == IDLE) && bus.in_valid && in_ready;

    an_mod_serial u_syn (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .step  (state == SYND),
        .din   (word[idx]),
        .s     (s)
    );

    // Extra top bit catches borrow (subtract) or carry (add) out of CW_W.
    always_comb begin
        delta = '0;
        delta = (CW_W+1)'(1) << (k - 6'd1);
        sum   = neg ? ({1'b0, word} + delta) : ({1'b0, word} - delta);
        mag   = {1'b0, k};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word      <= '0;
            idx       <= '0;
            k         <= '0;
            p         <= '0;
            neg       <= 1'b0;
            flags     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_cw    <= '0;
            out_syn   <= '0;
            out_loc   <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        word     <= bus.in_cw;
                        idx      <= 6'(CW_W - 1);
                        flags    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SYND;
                    end
                end
                SYND: begin
                    if (idx == '0)
                        state <= CHK;
                    else
                        idx <= idx - 6'd1;
                end
                CHK: begin
                    out_syn <= s;
                    if (s == '0) begin
                        flags.no_err <= 1'b1;
                        out_cw       <= word;
                        out_loc      <= '0;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        k     <= 6'd1;
                        p     <= R_W'(1);
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (s == p) begin
                        neg   <= 1'b0;
                        state <= CORR;
                    end else if (s == A_R - p) begin
                        neg   <= 1'b1;
                        state <= CORR;
                    end else if (k == 6'(NLOC)) begin
                        flags.uncorr <= 1'b1;
                        out_cw       <= word;
                        out_loc      <= '0;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end else begin
                        k <= k + 6'd1;
                        p <= mod_dbl(p, 1'b0);
                    end
                end
                CORR: begin
                    if (sum[CW_W]) begin
                        flags.uncorr <= 1'b1;
                        out_cw       <= word;
                        out_loc      <= '0;
                    end else begin
                        flags.corr <= 1'b1;
                        out_cw     <= sum[CW_W-1:0];
                        out_loc    <= neg ? (7'd0 - mag) : mag;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_cw     = out_cw;
    assign bus.out_syn    = out_syn;
    assign bus.out_loc    = out_loc;
    assign bus.out_no_err = flags.no_err;
    assign bus.out_corr   = flags.corr;
    assign bus.out_uncorr = flags.uncorr;

endmodule

// File: tb/tb_an_sec_decode_ctrl.sv
// Scoreboard bench for the AN SEC decoder against a residue/search model.
module tb_an_sec_decode_ctrl;
    import an_sec_pkg::*;

    typedef struct {
        logic [37:0] cw;
        logic [13:0] syn;
        logic [6:0]  loc;
        logic        no_err;
        logic        corr;
        logic        uncorr;
        longint      lat;
        longint      acc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   busy;
    longint cyc = 0;
    int     nchk = 0;
    int     nfail = 0;
    exp_t   q[$];
    logic   seen = 1'b0;

    an_sec_decode_ctrl_if bus ();

    an_sec_decode_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: residue, first matching +/-2^(k-1) mod A, then range-checked fix.
    function automatic exp_t model(input logic [37:0] cw);
        exp_t   e;
        longint s, m, v, c;
        int     l, ak;
        c = longint'(cw);
        s = c % A_CONST;
        l = 0;
        e.cw = cw; e.syn = 14'(s); e.loc = '0;
        e.no_err = 0; e.corr = 0; e.uncorr = 0; e.acc = 0;
        if (s == 0) begin
            e.no_err = 1; e.lat = 39;
            return e;
        end
        for (int kk = 1; kk <= NLOC && l == 0; kk++) begin
            m = (longint'(1) << (kk - 1)) % A_CONST;
            if (s == m) l = kk;
            else if (s == A_CONST - m) l = -kk;
        end
        if (l == 0) begin
            e.uncorr = 1; e.lat = 77;
            return e;
        end
        ak = (l > 0) ? l : -l;
        e.lat = 40 + ak;
        v = (l > 0) ? c - (longint'(1) << (ak - 1)) : c + (longint'(1) << (ak - 1));
        if (v < 0 || v >= (longint'(1) << 38)) begin
            e.uncorr = 1;
        end else begin
            e.corr = 1; e.cw = 38'(v); e.loc = 7'(l);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.out_valid && !seen) begin
            exp_t cur;
            seen = 1'b1;
            if (q.size() == 0) begin
                nchk++; nfail++;
                $display("FAIL unexpected_output: got cw %0d expected none", bus.out_cw);
            end else begin
                cur = q.pop_front();
                chk("out_cw", longint'(bus.out_cw), longint'(cur.cw));
                chk("out_syn", longint'(bus.out_syn), longint'(cur.syn));
                chk("out_loc", longint'(bus.out_loc), longint'(cur.loc));
                chk("out_no_err", longint'(bus.out_no_err), longint'(cur.no_err));
                chk("out_corr", longint'(bus.out_corr), longint'(cur.corr));
                chk("out_uncorr", longint'(bus.out_uncorr), longint'(cur.uncorr));
                chk("latency", cyc - cur.acc, cur.lat);
            end
        end else if (!bus.out_valid) begin
            seen = 1'b0;
        end
    end

    task automatic send(input logic [37:0] c);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_cw = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        e = model(c);
        e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_out_cw", longint'(bus.out_cw), 0);
        chk("rst_out_syn", longint'(bus.out_syn), 0);
        chk("rst_out_loc", longint'(bus.out_loc), 0);
        chk("rst_flags", longint'({bus.out_no_err, bus.out_corr, bus.out_uncorr}), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [37:0]  hold_cw;
        logic [13:0]  hold_syn;
        logic [6:0]   hold_loc;
        int           n;
        longint       base, c;
        logic [37:0]  dir[6];

        bus.in_valid = 1'b0;
        bus.in_cw = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;

        dir[0] = 38'd69185;
        dir[1] = 38'd69186;
        dir[2] = 38'd52801;
        dir[3] = 38'd69188;
        dir[4] = {38{1'b1}};
        dir[5] = 38'h3F_FFFF_FFFF;
        foreach (dir[i]) send(dir[i]);

        // Backpressure: result must hold and a second offer must be ignored.
        send(38'd69186);
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", longint'(bus.out_valid), 1);
        hold_cw = bus.out_cw;
        hold_syn = bus.out_syn;
        hold_loc = bus.out_loc;
        bus.in_valid = 1'b1;
        bus.in_cw = 38'd69185;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stable_cw", longint'(bus.out_cw), longint'(hold_cw));
            chk("bp_stable_syn", longint'(bus.out_syn), longint'(hold_syn));
            chk("bp_stable_loc", longint'(bus.out_loc), longint'(hold_loc));
            chk("bp_valid_held", longint'(bus.out_valid), 1);
            chk("bp_in_ready", longint'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_ignored_busy", longint'(busy), 0);
        chk("bp_ignored_ready", longint'(bus.in_ready), 1);

        // Reset during syndrome accumulation drops the in-flight word.
        send(38'd69187);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        void'(q.pop_back());
        #1;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        send(38'd69186);

        for (int i = 0; i < 40; i++) begin
            base = longint'(A_CONST) * longint'($urandom_range(0, 16777215));
            case ($urandom_range(0, 2))
                0: c = base;
                1: begin
                    if ($urandom_range(0, 1) == 1)
                        c = base + (longint'(1) << $urandom_range(0, 37));
                    else
                        c = base - (longint'(1) << $urandom_range(0, 37));
                end
                default: c = {longint'($urandom), longint'($urandom)};
            endcase
            send(38'(c));
        end

        n = 0;
        while ((q.size() != 0 || !bus.in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", longint'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
